// File: rtl/clock_mirror_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : clock_mirror_pkg
//  Description : Shared types and defaults for the clock mirror DDR data-pair
//                generator (clock_mirror_seq and mirror_phase_gen).
//                - state_e   : mirror FSM states
//                - DIV_W_DEF : default width of the divide selector
//                - CNT_W_DEF : default width of burst length / period counter
//                - FULL_RATE : div value meaning "one clock per mirror period"
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_mirror_pkg;

  localparam int DIV_W_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int FULL_RATE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage : clock_mirror_pkg
`default_nettype wire

// File: rtl/mirror_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mirror_phase_gen
//  Description : Phase counter, period-boundary flag and next-cycle D0/D1
//                pattern for the clock mirror.
//  Ports       :
//    clock_i     in   fabric clock
//    reset_i     in   asynchronous active-high reset
//    load_i      in   restart the phase counter at 0 on this edge
//    adv_i       in   advance the phase counter on this edge
//    div_cur_i   in   divide value governing the cycle now being emitted
//    div_nxt_i   in   divide value governing the next emitted cycle
//    inv_nxt_i   in   phase inversion governing the next emitted cycle
//    boundary_o  out  the cycle now being emitted is the last of its period
//    d0_nxt_o    out  D0 for the next cycle (ungated)
//    d1_nxt_o    out  D1 for the next cycle (ungated)
//  Revision    : 1.0 - initial release
// ============================================================================
module mirror_phase_gen
  import clock_mirror_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [DIV_W-1:0] div_cur_i,
  input  logic [DIV_W-1:0] div_nxt_i,
  input  logic             inv_nxt_i,
  output logic             boundary_o,
  output logic             d0_nxt_o,
  output logic             d1_nxt_o
);

  // One extra bit: a period of 2*d clocks needs phase values up to 2*d-1.
  localparam int PH_W = DIV_W + 1;

  logic [PH_W-1:0] ph_q;
  logic [PH_W-1:0] ph_d;
  logic [PH_W-1:0] w_last;
  logic            w_high;

  assign w_last     = {div_cur_i, 1'b0} - PH_W'(1);
  // At full rate every clock is a complete period.
  assign boundary_o = (div_cur_i == DIV_W'(FULL_RATE)) || (ph_q == w_last);

  always_comb begin
    ph_d = ph_q;
    if (load_i || (adv_i && boundary_o)) begin
      ph_d = '0;
    end else if (adv_i) begin
      ph_d = ph_q + PH_W'(1);
    end
  end

  // Pattern is evaluated on the phase the next cycle will carry, so the
  // registered pin value lines up with the phase counter.
  assign w_high = (ph_d < {1'b0, div_nxt_i});

  always_comb begin
    if (div_nxt_i == DIV_W'(FULL_RATE)) begin
      d0_nxt_o = ~inv_nxt_i;
      d1_nxt_o = inv_nxt_i;
    end else begin
      d0_nxt_o = w_high ^ inv_nxt_i;
      d1_nxt_o = w_high ^ inv_nxt_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_d;
    end
  end

endmodule : mirror_phase_gen
`default_nettype wire

// File: rtl/clock_mirror_seq.sv
`default_nettype none
// ============================================================================
//  Module      : clock_mirror_seq
//  Description : Per-cycle DDR data-pair generator feeding an ODDR2 clock
//                mirror (C0 = clock, C1 = clock_180). Emits a gated,
//                optionally divided, burst-capable copy of clock. Start, stop
//                and divide changes only take effect at mirror period
//                boundaries; the pin always parks low.
//  Config      : MIRROR_PHASE_INV_EN - adds input phase_inv, latched with
//                div_sel; when set the emitted pair is inverted/swapped.
//  Ports       :
//    clock       in   fabric clock (also C0 of the mirror stage)
//    reset       in   asynchronous active-high reset
//    enable      in   1 = run, 0 = finish current period and park low
//    div_sel     in   0 = full rate, d>0 = period of 2*d clocks
//    burst_len   in   0 = continuous, n>0 = stop after n periods
//    phase_inv   in   (MIRROR_PHASE_INV_EN only) invert emitted phase
//    d0          out  mirror D0 (first half of clock period)
//    d1          out  mirror D1 (second half of clock period)
//    running     out  1 while in RUN or STOP
//    done        out  one-clock pulse on entry to IDLE
//    period_cnt  out  complete periods since last start (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_mirror_seq
  import clock_mirror_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_sel,
  input  logic [CNT_W-1:0] burst_len,
`ifdef MIRROR_PHASE_INV_EN
  input  logic             phase_inv,
`endif
  output logic             d0,
  output logic             d1,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] period_cnt
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arm_q, arm_d;
  logic             d0_q, d0_d;
  logic             d1_q, d1_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             inv_q, inv_d;

  logic             w_active;
  logic             w_start;
  logic             w_boundary;
  logic             w_relatch;
  logic             w_burst_hit;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_d0_nxt;
  logic             w_d1_nxt;
  logic             w_inv_src;

`ifdef MIRROR_PHASE_INV_EN
  assign w_inv_src = phase_inv;
`else
  assign w_inv_src = 1'b0;
`endif

  assign w_active    = (state_q != IDLE);
  // arm_q blocks a self-repeating burst: after a burst ends with enable
  // still high, enable must be seen low before another start.
  assign w_start     = (state_q == IDLE) && enable && arm_q;
  assign w_cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign w_burst_hit = (burst_q != '0) && (w_cnt_inc == burst_q);

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    arm_d     = arm_q;
    done_d    = 1'b0;
    w_relatch = 1'b0;
    case (state_q)
      IDLE: begin
        if (!enable) begin
          arm_d = 1'b1;
        end
        if (w_start) begin
          state_d   = RUN;
          burst_d   = burst_len;
          cnt_d     = '0;
          w_relatch = 1'b1;
        end
      end
      RUN: begin
        if (w_boundary) begin
          cnt_d     = w_cnt_inc;
          w_relatch = 1'b1;
          if (!enable || w_burst_hit) begin
            state_d = IDLE;
            done_d  = 1'b1;
            arm_d   = !(w_burst_hit && enable);
          end
        end else if (!enable) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // A raised enable does not cancel the stop; it restarts from IDLE.
        if (w_boundary) begin
          cnt_d   = w_cnt_inc;
          state_d = IDLE;
          done_d  = 1'b1;
          arm_d   = !(w_burst_hit && enable);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Divide ratio and inversion are only picked up on start or at a boundary,
  // so a period in flight never changes shape.
  assign div_d = w_relatch ? div_sel   : div_q;
  assign inv_d = w_relatch ? w_inv_src : inv_q;

  assign run_d = (state_d != IDLE);
  assign d0_d  = run_d & w_d0_nxt;
  assign d1_d  = run_d & w_d1_nxt;

  mirror_phase_gen #(
    .DIV_W (DIV_W)
  ) u_phase_gen (
    .clock_i    (clock),
    .reset_i    (reset),
    .load_i     (w_start),
    .adv_i      (w_active),
    .div_cur_i  (div_q),
    .div_nxt_i  (div_d),
    .inv_nxt_i  (inv_d),
    .boundary_o (w_boundary),
    .d0_nxt_o   (w_d0_nxt),
    .d1_nxt_o   (w_d1_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      arm_q   <= 1'b1;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      run_q   <= run_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
    end
  end

  assign d0         = d0_q;
  assign d1         = d1_q;
  assign running    = run_q;
  assign done       = done_q;
  assign period_cnt = cnt_q;

endmodule : clock_mirror_seq
`default_nettype wire
